core_sequencer: RTL and testbench

Multi-cycle execution sequencer for the ysyx_25030077 core, the successor to the single-cycle top-level datapath. It owns the PC and instruction register and drives a fetch → execute → optional memory → writeback state machine. Instruction and data memories are reached over valid/ready handshakes with arbitrary latency. The existing combinational decode, immediate, ALU and next-PC logic hang off its `inst`/`pc` outputs and feed back decode flags and `pc_next`.

---
 rtl/core_sequencer.sv | 150 +++++++++++++++
 tb/tb_core_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/execute/memory/writeback sequencer owning pc and inst.
// Optional CORE_SEQ_PERF_EN adds 64-bit cycle and retired-instruction counters.
//
// state        | meaning
// S_IDLE       | one cycle after reset before the first fetch
// S_FETCH_REQ  | ifu_req_valid high, waiting for ifu_req_ready
// S_FETCH_WAIT | waiting for ifu_rsp_valid, latches inst
// S_EXEC       | one cycle, samples decode flags and pc_next alignment
// S_MEM_REQ    | lsu_req_valid high, waiting for lsu_req_ready
// S_MEM_WAIT   | waiting for lsu_rsp_valid
// S_WB         | rf_wen pulse, pc <= pc_next
// S_HALT       | terminal until reset, halt_code held
module core_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clock,
  input  logic            reset,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_data,
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  input  logic            lsu_rsp_valid,
  input  logic            dec_is_mem,
  input  logic            dec_is_break,
  input  logic            dec_illegal,
  input  logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  output logic            rf_wen,
  output logic            halted,
  output logic [1:0]      halt_code
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [63:0]     perf_cycles,
  output logic [63:0]     perf_instret
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [1:0] HC_BREAK   = 2'd1;
  localparam logic [1:0] HC_ILLEGAL = 2'd2;
  localparam logic [1:0] HC_MISALN  = 2'd3;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_halt_code;
  logic [1:0]      w_halt_code_nxt;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic            w_misal;

  assign w_misal = (pc_next[1:0] != 2'b00);

  always_comb begin
    w_state_nxt     = r_state;
    w_halt_code_nxt = r_halt_code;
    case (r_state)
      S_IDLE:       w_state_nxt = S_FETCH_REQ;
      S_FETCH_REQ:  if (ifu_req_ready) w_state_nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: if (ifu_rsp_valid) w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (dec_illegal) begin
          w_state_nxt     = S_HALT;
          w_halt_code_nxt = HC_ILLEGAL;
        end else if (dec_is_break) begin
          w_state_nxt     = S_HALT;
          w_halt_code_nxt = HC_BREAK;
        end else if (!dec_is_mem && w_misal) begin
          w_state_nxt     = S_HALT;
          w_halt_code_nxt = HC_MISALN;
        end else if (dec_is_mem) begin
          w_state_nxt = S_MEM_REQ;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_MEM_REQ:    if (lsu_req_ready) w_state_nxt = S_MEM_WAIT;
      S_MEM_WAIT: begin
        // memory ops defer the alignment check until the access completes
        if (lsu_rsp_valid) begin
          if (w_misal) begin
            w_state_nxt     = S_HALT;
            w_halt_code_nxt = HC_MISALN;
          end else begin
            w_state_nxt = S_WB;
          end
        end
      end
      S_WB:         w_state_nxt = S_FETCH_REQ;
      S_HALT:       w_state_nxt = S_HALT;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_halt_code <= 2'd0;
      r_pc        <= RESET_PC;
      r_inst      <= 32'h0000_0013;
    end else begin
      r_state     <= w_state_nxt;
      r_halt_code <= w_halt_code_nxt;
      if (r_state == S_WB) r_pc <= pc_next;
      if ((r_state == S_FETCH_WAIT) && ifu_rsp_valid) r_inst <= ifu_rsp_data;
    end
  end

  assign ifu_req_valid = (r_state == S_FETCH_REQ);
  assign ifu_req_addr  = r_pc;
  assign lsu_req_valid = (r_state == S_MEM_REQ);
  assign rf_wen        = (r_state == S_WB);
  assign halted        = (r_state == S_HALT);
  assign halt_code     = r_halt_code;
  assign pc            = r_pc;
  assign inst          = r_inst;

`ifdef CORE_SEQ_PERF_EN
  logic [63:0] r_perf_cycles;
  logic [63:0] r_perf_instret;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_cycles  <= 64'd0;
      r_perf_instret <= 64'd0;
    end else begin
      if (r_state != S_HALT) r_perf_cycles <= r_perf_cycles + 64'd1;
      if (r_state == S_WB) r_perf_instret <= r_perf_instret + 64'd1;
    end
  end

  assign perf_cycles  = r_perf_cycles;
  assign perf_instret = r_perf_instret;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: vector table plus reset, chained-fetch
// and (with CORE_SEQ_PERF_EN) performance-counter sequences.
module tb_core_sequencer;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBRK   = 32'h0010_0073;
  localparam logic [31:0] LW     = 32'h0002_a303;
  localparam logic [31:0] SW     = 32'h0062_a023;
  localparam logic [31:0] ADD    = 32'h00b5_0533;
  localparam logic [31:0] BAD    = 32'hffff_ffff;
  localparam logic [31:0] JUNK   = 32'hdead_beef;

  logic        clock, reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_req_addr, ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
  logic        dec_is_mem, dec_is_break, dec_illegal;
  logic [31:0] pc_next, pc, inst;
  logic        rf_wen, halted;
  logic [1:0]  halt_code;
  logic        pc_adj;
`ifdef CORE_SEQ_PERF_EN
  logic [63:0] perf_cycles, perf_instret;
`endif

  core_sequencer dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr), .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_data(ifu_rsp_data), .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .dec_is_mem(dec_is_mem), .dec_is_break(dec_is_break),
    .dec_illegal(dec_illegal), .pc_next(pc_next), .pc(pc), .inst(inst),
    .rf_wen(rf_wen), .halted(halted), .halt_code(halt_code)
`ifdef CORE_SEQ_PERF_EN
    , .perf_cycles(perf_cycles), .perf_instret(perf_instret)
`endif
  );

  // external next-PC logic: pc+4, optionally skewed by 2 to force misalignment
  assign pc_next = pc + 32'd4 + {30'd0, pc_adj, 1'b0};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] ins;
    logic        mem, brk, ill, mis, stray;
    int          f_rdy, f_lat, m_rdy, m_lat;
    logic [1:0]  code;
    int          cycles;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic vec_t mkv(logic [31:0] ins, logic mem, logic brk, logic ill,
                               logic mis, logic stray, int f_rdy, int f_lat,
                               int m_rdy, int m_lat, logic [1:0] code, int cycles);
    vec_t v;
    v.ins = ins; v.mem = mem; v.brk = brk; v.ill = ill; v.mis = mis;
    v.stray = stray; v.f_rdy = f_rdy; v.f_lat = f_lat; v.m_rdy = m_rdy;
    v.m_lat = m_lat; v.code = code; v.cycles = cycles;
    return v;
  endfunction

  task automatic idle_inputs();
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_data = JUNK;
    lsu_req_ready = 0; lsu_rsp_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    dec_is_mem = 0; dec_is_break = 0; dec_illegal = 0; pc_adj = 0;
    reset = 0;
    step();
    step();
    chk("rst_ifu_req_valid", ifu_req_valid, 0);
    chk("rst_lsu_req_valid", lsu_req_valid, 0);
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_halted", halted, 0);
    chk("rst_halt_code", halt_code, 0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, NOP);
`ifdef CORE_SEQ_PERF_EN
    chk("rst_perf_cycles", perf_cycles, 0);
    chk("rst_perf_instret", perf_instret, 0);
`endif
    reset = 1;
    step();
  endtask

  // Drives one instruction from its first FETCH_REQ sample to completion.
  task automatic run_instr(input vec_t v, input logic [31:0] start, input string tag,
                           output int wb_cyc);
    int n, f_wait, m_wait, f_cnt, m_cnt, fr_n, m_rsp_n, req_n;
    bit pend_f, pend_m, done;
    dec_is_mem = v.mem; dec_is_break = v.brk; dec_illegal = v.ill; pc_adj = v.mis;
    f_wait = 0; m_wait = 0; f_cnt = 0; m_cnt = 0; fr_n = 0; m_rsp_n = -10;
    pend_f = 0; pend_m = 0; done = 0; wb_cyc = -1;
    n = 0;
    while (!ifu_req_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_fetch_start"}, ifu_req_valid, 1);
    n = 0;
    while (!done && n < 60) begin
      n++;
      if (rf_wen || halted) begin
        done = 1;
        wb_cyc = cyc;
      end else begin
        if (ifu_req_valid) begin
          fr_n++;
          chk({tag, "_ifu_addr"}, ifu_req_addr, start);
        end
        ifu_rsp_valid = 0; ifu_rsp_data = JUNK;
        if (pend_f) begin
          f_cnt--;
          if (f_cnt == 0) begin
            ifu_rsp_valid = 1; ifu_rsp_data = v.ins; pend_f = 0;
          end
        end else if (v.stray) ifu_rsp_valid = 1;
        ifu_req_ready = 0;
        if (ifu_req_valid) begin
          if (f_wait == v.f_rdy) begin
            ifu_req_ready = 1; pend_f = 1; f_cnt = v.f_lat;
          end
          f_wait++;
        end
        lsu_rsp_valid = 0;
        if (pend_m) begin
          m_cnt--;
          if (m_cnt == 0) begin
            lsu_rsp_valid = 1; pend_m = 0; m_rsp_n = n;
          end
        end else if (v.stray) lsu_rsp_valid = 1;
        lsu_req_ready = 0;
        if (lsu_req_valid) begin
          if (m_wait == v.m_rdy) begin
            lsu_req_ready = 1; pend_m = 1; m_cnt = v.m_lat;
          end
          m_wait++;
        end
        step();
      end
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cycles"}, n, v.cycles);
    chk({tag, "_fr_cycles"}, fr_n, v.f_rdy + 1);
    chk({tag, "_inst"}, inst, v.ins);
    chk({tag, "_halt_code"}, halt_code, v.code);
    idle_inputs();
    if (v.code == 2'd0) begin
      if (v.mem) chk({tag, "_wen_after_lsu_rsp"}, n - m_rsp_n, 1);
      step();
      chk({tag, "_wen_pulse"}, rf_wen, 0);
      chk({tag, "_pc_adv"}, pc, start + 32'd4);
      chk({tag, "_next_fetch"}, ifu_req_valid, 1);
    end else begin
      chk({tag, "_halted"}, halted, 1);
      chk({tag, "_pc_frozen"}, pc, start);
      req_n = 0;
      ifu_req_ready = 1; lsu_req_ready = 1;
      for (int k = 0; k < 20; k++) begin
        ifu_rsp_valid = 1; lsu_rsp_valid = 1;
        step();
        if (ifu_req_valid || lsu_req_valid || !halted) req_n++;
      end
      chk({tag, "_halt_no_req"}, req_n, 0);
      chk({tag, "_halt_code_held"}, halt_code, v.code);
      chk({tag, "_halt_inst"}, inst, v.ins);
      chk({tag, "_halt_pc"}, pc, start);
      idle_inputs();
    end
  endtask

  vec_t vecs[12];

  initial begin
    int c0, c1, c2;
    vec_t nop_v;
    vecs[0]  = mkv(NOP,  0, 0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 4);
    vecs[1]  = mkv(NOP,  0, 0, 0, 0, 1, 5, 1, 0, 1, 2'd0, 9);
    vecs[2]  = mkv(NOP,  0, 0, 0, 0, 1, 0, 3, 0, 1, 2'd0, 6);
    vecs[3]  = mkv(LW,   1, 0, 0, 0, 0, 0, 1, 0, 3, 2'd0, 8);
    vecs[4]  = mkv(SW,   1, 0, 0, 0, 1, 0, 1, 2, 1, 2'd0, 8);
    vecs[5]  = mkv(EBRK, 0, 1, 0, 0, 0, 0, 1, 0, 1, 2'd1, 4);
    vecs[6]  = mkv(BAD,  0, 1, 1, 0, 0, 0, 1, 0, 1, 2'd2, 4);
    vecs[7]  = mkv(ADD,  0, 0, 0, 1, 0, 0, 1, 0, 1, 2'd3, 4);
    vecs[8]  = mkv(LW,   1, 0, 0, 1, 0, 0, 1, 0, 2, 2'd3, 7);
    vecs[9]  = mkv(LW,   1, 1, 0, 0, 1, 0, 1, 0, 1, 2'd1, 4);
    vecs[10] = mkv(BAD,  1, 0, 1, 1, 1, 0, 1, 0, 1, 2'd2, 4);
    vecs[11] = mkv(SW,   1, 0, 0, 0, 1, 1, 2, 0, 1, 2'd0, 8);
    nop_v    = vecs[0];

    for (int i = 0; i < 12; i++) begin
      do_reset();
      run_instr(vecs[i], RST_PC, $sformatf("v%0d", i), c0);
    end

    // three back-to-back nops: successive addresses, rf_wen every 4 cycles
    do_reset();
    run_instr(nop_v, RST_PC,          "seq0", c0);
    run_instr(nop_v, RST_PC + 32'd4,  "seq1", c1);
    run_instr(nop_v, RST_PC + 32'd8,  "seq2", c2);
    chk("seq_wen_gap01", c1 - c0, 4);
    chk("seq_wen_gap12", c2 - c1, 4);

    // reset asserted mid-fetch, stale response after release must be ignored
    do_reset();
    run_instr(nop_v, RST_PC, "mid0", c0);
    ifu_req_ready = 0;
    step();
    chk("mid_fetch_valid", ifu_req_valid, 1);
    chk("mid_fetch_addr", ifu_req_addr, RST_PC + 32'd4);
    #2;
    reset = 0;
    #1;
    chk("mid_rst_valid_drop", ifu_req_valid, 0);
    chk("mid_rst_pc", pc, RST_PC);
    step();
    ifu_rsp_valid = 1; ifu_rsp_data = JUNK;
    reset = 1;
    step();
    chk("mid_stale_rsp_inst", inst, NOP);
    run_instr(vecs[2], RST_PC, "mid1", c0);

`ifdef CORE_SEQ_PERF_EN
    do_reset();
    for (int i = 0; i < 10; i++) run_instr(nop_v, RST_PC + 32'(4 * i), $sformatf("pf%0d", i), c0);
    run_instr(vecs[5], RST_PC + 32'd40, "pf_brk", c0);
    chk("perf_instret", perf_instret, 10);
    chk("perf_cycles_frozen", perf_cycles, 44);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
